// File: rtl/aes_ctr_ctrl_if.sv
// aes_ctr_ctrl_if: config, data-stream and cipher-port bundle for aes_ctr_ctrl.
interface aes_ctr_ctrl_if #(
    parameter int BLK_W = 128,
    parameter int KEY_W = 256
);
    logic             cfg_load;
    logic [KEY_W-1:0] cfg_key;
    logic [BLK_W-1:0] cfg_iv;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;
    logic             ctr_wrap;
    logic             aes_start;
    logic [BLK_W-1:0] aes_plaintext;
    logic [KEY_W-1:0] aes_key;
    logic             aes_done;
    logic [BLK_W-1:0] aes_ciphertext;
    modport master (
        output cfg_load, cfg_key, cfg_iv, in_valid, in_data, out_ready, aes_done, aes_ciphertext,
        input  in_ready, out_valid, out_data, ctr_wrap, aes_start, aes_plaintext, aes_key
    );
    modport slave (
        input  cfg_load, cfg_key, cfg_iv, in_valid, in_data, out_ready, aes_done, aes_ciphertext,
        output in_ready, out_valid, out_data, ctr_wrap, aes_start, aes_plaintext, aes_key
    );
endinterface

// File: rtl/aes_ctr_ctrl.sv
// aes_ctr_ctrl: AES-CTR stream engine; prefetches one keystream block per counter
// from an external start/done cipher and XORs it onto a valid/ready data stream.
module aes_ctr_ctrl #(
    parameter int BLK_W = 128,
    parameter int KEY_W = 256,
    parameter int CTR_W = 32
) (
    input logic          clk,
    input logic          reset,
    aes_ctr_ctrl_if.slave bus
);
    typedef enum logic [2:0] {UNCFG, GEN, WAIT, HAVE, EXH, DRAIN} state_e;
    localparam logic [BLK_W-1:0] CTR_MASK = {BLK_W{1'b1}} >> (BLK_W - CTR_W);

    state_e           state_q;
    logic [KEY_W-1:0] key_q, aes_key_q;
    logic [BLK_W-1:0] ctr_blk_q, ks_q, out_data_q, aes_pt_q, ctr_d;
    logic             ks_valid_q, out_valid_q, ctr_wrap_q, aes_start_q;
    logic             in_hs, at_max;

    assign bus.in_ready      = (state_q == HAVE) && ks_valid_q && (!out_valid_q || bus.out_ready);
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.ctr_wrap      = ctr_wrap_q;
    assign bus.aes_start     = aes_start_q;
    assign bus.aes_plaintext = aes_pt_q;
    assign bus.aes_key       = aes_key_q;

    assign in_hs  = bus.in_valid && bus.in_ready;
    assign ctr_d  = (ctr_blk_q & ~CTR_MASK) | ((ctr_blk_q + BLK_W'(1)) & CTR_MASK);
    assign at_max = &(ctr_blk_q | ~CTR_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNCFG;
            key_q       <= '0;
            aes_key_q   <= '0;
            ctr_blk_q   <= '0;
            ks_q        <= '0;
            out_data_q  <= '0;
            aes_pt_q    <= '0;
            ks_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ctr_wrap_q  <= 1'b0;
            aes_start_q <= 1'b0;
        end else begin
            aes_start_q <= 1'b0;
            if (in_hs) begin
                out_data_q  <= bus.in_data ^ ks_q;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A cipher op in flight must finish before the new key reaches the cipher.
            if (bus.cfg_load) begin
                key_q      <= bus.cfg_key;
                ctr_blk_q  <= bus.cfg_iv;
                ctr_wrap_q <= 1'b0;
                ks_valid_q <= 1'b0;
                if (state_q == GEN || ((state_q == WAIT || state_q == DRAIN) && !bus.aes_done)) begin
                    state_q <= DRAIN;
                end else begin
                    state_q     <= GEN;
                    aes_start_q <= 1'b1;
                    aes_pt_q    <= bus.cfg_iv;
                    aes_key_q   <= bus.cfg_key;
                end
            end else begin
                case (state_q)
                    GEN: state_q <= WAIT;
                    WAIT: if (bus.aes_done) begin
                        ks_q       <= bus.aes_ciphertext;
                        ks_valid_q <= 1'b1;
                        state_q    <= HAVE;
                    end
                    DRAIN: if (bus.aes_done) begin
                        state_q     <= GEN;
                        aes_start_q <= 1'b1;
                        aes_pt_q    <= ctr_blk_q;
                        aes_key_q   <= key_q;
                    end
                    HAVE: if (in_hs) begin
                        ks_valid_q <= 1'b0;
                        ctr_blk_q  <= ctr_d;
                        if (at_max) begin
                            ctr_wrap_q <= 1'b1;
                            state_q    <= EXH;
                        end else begin
                            state_q     <= GEN;
                            aes_start_q <= 1'b1;
                            aes_pt_q    <= ctr_d;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// tb_aes_ctr_ctrl: directed + randomized checks of aes_ctr_ctrl against a stream-level
// CTR model, using a keyed stand-in cipher with variable latency.
module tb_aes_ctr_ctrl;
    localparam int BLK_W = 128;
    localparam int KEY_W = 256;
    localparam int CTR_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_ctr_ctrl_if #(.BLK_W(BLK_W), .KEY_W(KEY_W)) bus ();
    aes_ctr_ctrl #(.BLK_W(BLK_W), .KEY_W(KEY_W), .CTR_W(CTR_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_done = 0;
    int tb_lat = -1;
    bit rnd_ready = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] p);
        logic [127:0] x;
        x = (p ^ k[127:0]) * 128'h9E3779B97F4A7C15F39CC0605CEDC835;
        return x ^ {x[63:0], x[127:64]} ^ k[255:128];
    endfunction

    // Stand-in cipher: not reset by the controller, so in-flight results can arrive late.
    logic         c_busy = 1'b0;
    int           c_cnt = 0;
    logic [255:0] c_key;
    logic [127:0] c_pt;
    initial bus.aes_done = 1'b0;
    always @(posedge clk) begin
        bus.aes_done <= 1'b0;
        if (c_busy) begin
            if (c_cnt == 0) begin
                bus.aes_done       <= 1'b1;
                bus.aes_ciphertext <= cipher(c_key, c_pt);
                c_busy             <= 1'b0;
            end else c_cnt <= c_cnt - 1;
        end
        if (bus.aes_start) begin
            c_busy <= 1'b1;
            c_cnt  <= (tb_lat >= 0) ? tb_lat : int'($urandom_range(0, 5));
            c_key  <= bus.aes_key;
            c_pt   <= bus.aes_plaintext;
        end
    end

    // Stream model: after cfg(key, iv) the i-th accepted block is XORed with
    // cipher(key, iv with its low CTR_W bits advanced by i); nothing follows an all-ones field.
    logic [127:0] exp_q[$];
    logic [255:0] m_key;
    logic [127:0] m_ctr;
    bit           m_live = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_data;
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_live = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
            if (bus.aes_start) begin
                n_start++;
                chk("start_allowed", m_live, 1);
                chk("start_pt", bus.aes_plaintext, m_ctr);
                chk("start_key", bus.aes_key, m_key);
            end
            if (bus.aes_done) n_done++;
            if (bus.cfg_load) begin
                m_key = bus.cfg_key;
                m_ctr = bus.cfg_iv;
                m_live = 1;
            end else if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(bus.in_data ^ cipher(m_key, m_ctr));
                if (&m_ctr[CTR_W-1:0]) m_live = 0;
                m_ctr[CTR_W-1:0] = m_ctr[CTR_W-1:0] + 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("out_unexpected", bus.out_valid, 0);
                else chk("out_data", bus.out_data, exp_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input logic [255:0] k, input logic [127:0] iv);
        bus.cfg_key = k;
        bus.cfg_iv = iv;
        bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0;
    endtask

    task automatic send(input logic [127:0] d);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            ok = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic wait_start();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            seen = bus.aes_start;
            if (!seen) @(negedge clk);
        end
        chk("start_seen", seen, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_ctr_wrap"}, bus.ctr_wrap, 0);
        chk({tag, "_aes_start"}, bus.aes_start, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_aes_pt"}, bus.aes_plaintext, 0);
        chk({tag, "_aes_key"}, bus.aes_key, 0);
    endtask

    initial begin
        logic [255:0] k_a, k_b;
        logic [127:0] iv_a, iv_b, d;
        int d0, s0;
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] k_a, k_b;
        logic [127:0] iv_a, iv_b, d;
        int d0, s0;
        bus.cfg_load = 0; bus.cfg_key = '0; bus.cfg_iv = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
        tick(3);
        chk_reset("rst");
        reset = 1'b0;
        tick(2);
        chk("uncfg_in_ready", bus.in_ready, 0);

        k_a = {1'b1, 255'b0};
        cfg(k_a, '0);
        chk("cfg_start_latency", bus.aes_start, 1);
        send('0);
        send({128{1'b1}});
        tick(3);

        k_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        iv_a = {$urandom, $urandom, $urandom, $urandom};
        iv_a[7:0] = 8'h00;
        cfg(k_b, iv_a);
        bus.out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_data", bus.out_data, d ^ cipher(k_b, iv_a));
            chk("stall_no_accept", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) send({$urandom, $urandom, $urandom, $urandom});
        tick(3);
        chk("four_blocks_pt", bus.aes_plaintext, {iv_a[127:8], 8'h04});

        rnd_ready = 1;
        iv_a = {$urandom, $urandom, $urandom, $urandom};
        iv_a[7:0] = 8'($urandom_range(0, 200));
        cfg(k_b ^ {8{$urandom}}, iv_a);
        for (int i = 0; i < 24; i++) send({$urandom, $urandom, $urandom, $urandom});
        rnd_ready = 0;
        bus.out_ready = 1'b1;
        tick(3);

        iv_b = {$urandom, $urandom, $urandom, $urandom};
        iv_b[7:0] = 8'hfe;
        cfg(k_a, iv_b);
        send({$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom, $urandom, $urandom});
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("wrap_flag", bus.ctr_wrap, 1);
            chk("wrap_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("wrap_pt_upper", bus.aes_plaintext, {iv_b[127:8], 8'hff});
        cfg(k_a, iv_a);
        chk("wrap_cleared", bus.ctr_wrap, 0);
        send({$urandom, $urandom, $urandom, $urandom});
        tick(3);

        tb_lat = 8;
        k_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k_b = ~k_a;
        iv_a = {$urandom, $urandom, $urandom, $urandom};
        iv_b = {$urandom, $urandom, $urandom, $urandom};
        cfg(k_a, iv_a);
        wait_start();
        tick(2);
        d0 = n_done;
        cfg(k_b, iv_b);
        for (int i = 0; i < 40 && !bus.aes_start; i++) begin
            chk("drain_key_held", bus.aes_key, k_a);
            chk("drain_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        chk("abort_restart", bus.aes_start, 1);
        chk("abort_discards", n_done - d0, 1);
        chk("abort_new_pt", bus.aes_plaintext, iv_b);
        chk("abort_new_key", bus.aes_key, k_b);
        tb_lat = -1;
        send({$urandom, $urandom, $urandom, $urandom});
        tick(3);

        tb_lat = 8;
        cfg(k_a, iv_a);
        wait_start();
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        reset = 1'b0;
        d0 = n_done;
        s0 = n_start;
        tick(15);
        chk("late_done_seen", n_done - d0, 1);
        chk("late_no_start", n_start - s0, 0);
        chk("late_out_valid", bus.out_valid, 0);
        chk("late_in_ready", bus.in_ready, 0);
        chk("late_aes_pt", bus.aes_plaintext, 0);
        tb_lat = -1;

        bus.out_ready = 1'b1;
        tick(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
